// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles while enabled.
// Held at zero while disabled so every enable starts a fresh full period.
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the last cycle of the period; wrap to zero so periods abut.
    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Buffered serial frame transmitter: collects bytes while idle, then sends
// them back-to-back as start/data/stop frames on an idle-high line.
//
// state    | meaning
// ST_IDLE  | line high, accepting get/send
// ST_START | start bit (line low) for one bit period
// ST_DATA  | data bits of byte rd_idx, order set by LSB_FIRST
// ST_STOP  | STOP_BITS periods of line high, then next byte or idle
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int MAX_BYTES    = 6,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                data,
    input  logic                             get,
    input  logic                             send,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(MAX_BYTES+1)-1:0]   level,
    output logic                             overflow
);

    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] buf_q [MAX_BYTES];

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   rd_idx_q, rd_idx_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic            ovf_q, ovf_d;
    logic            tick;
    logic            get_ok;
    logic            tx_bit;

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    assign get_ok = (state_q == ST_IDLE) && get && (level_q < LW'(MAX_BYTES));

    // Buffer write port; contents are only meaningful below level, so no reset.
    always_ff @(posedge clk) begin
        if (get_ok) begin
            buf_q[level_q] <= data;
        end
    end

    // Current line data bit from the byte being transmitted.
    always_comb begin
        if (LSB_FIRST != 0) begin
            tx_bit = buf_q[rd_idx_q][bit_idx_q];
        end else begin
            tx_bit = buf_q[rd_idx_q][BW'(DATA_W - 1) - bit_idx_q];
        end
    end

    // Next-state logic and line outputs.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        rd_idx_d   = rd_idx_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        ovf_d      = ovf_q;
        tx         = IDLE_LEVEL;

        case (state_q)
            ST_IDLE: begin
                if (get_ok) begin
                    level_d = level_q + LW'(1);
                end else if (get) begin
                    ovf_d = 1'b1;
                end
                // A get accepted this cycle counts, so get+send with an empty buffer still sends.
                if (send && ((level_q != '0) || get_ok)) begin
                    state_d  = ST_START;
                    rd_idx_d = '0;
                end
            end
            ST_START: begin
                tx = START_LEVEL;
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                tx = tx_bit;
                if (tick) begin
                    if (bit_idx_q == BW'(DATA_W - 1)) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                tx = IDLE_LEVEL;
                if (tick) begin
                    if ((STOP_BITS > 1) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if ((rd_idx_q + LW'(1)) < level_q) begin
                        state_d  = ST_START;
                        rd_idx_d = rd_idx_q + LW'(1);
                    end else begin
                        state_d  = ST_IDLE;
                        level_d  = '0;
                        rd_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress and empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            rd_idx_q   <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            rd_idx_q   <= rd_idx_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, bits per byte.
REQ-002 Parameter MAX_BYTES, default 6, buffer depth in bytes (min 1).
REQ-003 Parameter CLKS_PER_BIT, default 4, clk cycles each line bit is held (min 1).
REQ-004 Parameter STOP_BITS, default 1, idle-high stop bits per byte (1 or 2).
REQ-005 Parameter LSB_FIRST, default 1, data bit order on the line (1 = LSB first).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 data  input  DATA_W  byte presented with get.
REQ-009 get  input  1  append data to buffer this cycle.
REQ-010 send  input  1  start transmission of all buffered bytes.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high while transmitting.
REQ-013 level  output  $clog2(MAX_BYTES+1)  bytes currently buffered.
REQ-014 overflow  output  1  sticky flag: a get was dropped.

Function
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE + get + level<MAX_BYTES: store data at slot level; level increments next cycle.
REQ-017 IDLE + get + level==MAX_BYTES: byte dropped; level unchanged; overflow set next cycle.
REQ-018 get in any non-IDLE state: ignored; overflow unchanged.
REQ-019 IDLE + send + (level>0 or accepted get same cycle): go to START next cycle; busy=1 and tx=0 from that cycle.
REQ-020 Simultaneous get and send in IDLE: byte is stored first and included in the transmission.
REQ-021 IDLE + send + level==0 + no get: ignored; stay IDLE.
REQ-022 send outside IDLE: ignored.
REQ-023 Every line bit holds exactly CLKS_PER_BIT cycles, timed by one bit-period counter.
REQ-024 START: tx=0 for one bit period, then DATA.
REQ-025 DATA: DATA_W bits of the current byte, order set by LSB_FIRST, then STOP.
REQ-026 STOP: tx=1 for STOP_BITS bit periods; then START for the next byte if any remain, else IDLE.
REQ-027 Bytes go out in load order (slot 0 first); frames are back-to-back with no extra idle.
REQ-028 On return to IDLE: level=0, busy=0, tx=1; the following cycle accepts get and send.
REQ-029 Transmission of N bytes: busy high exactly N*(1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-030 overflow clears only on reset.

Reset
REQ-031 rst high at a clock edge: state=IDLE, tx=1, busy=0, level=0, overflow=0, counters=0, next cycle.
REQ-032 rst mid-transmission aborts immediately; buffered bytes discarded; no partial frame resumes.
REQ-033 rst overrides get and send in the same cycle.
REQ-034 Buffer contents need no reset; they are unreadable while level==0.

Structure
REQ-035 Shared package serial_pkg holds the state enumeration and the line-level constants (IDLE_LEVEL=1, START_LEVEL=0).
REQ-036 One sub-module baud_tick: counter of width $clog2(CLKS_PER_BIT), pulses a one-cycle tick every CLKS_PER_BIT cycles while enabled and restarts at 0 when enable rises.
REQ-037 Buffer is a register array indexed by level (write) and by a read index (transmit), not a wide shift register.

Verification
REQ-038 Defaults; get 0xA5, send next cycle -> tx 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; level 0 after.
REQ-039 get 0x01,0x02,0x03, then send -> three back-to-back 40-cycle frames in order 0x01,0x02,0x03; busy high 120 cycles.
REQ-040 Seven gets (0x10..0x16) in IDLE -> level=6, overflow=1, transmission carries 0x10..0x15 only.
REQ-041 get 0x3C with send in the same cycle, level 0 -> single frame of 0x3C; send with level 0 and no get -> tx stays 1, busy 0.
REQ-042 rst asserted 17 cycles into a 2-byte send -> next cycle tx=1, busy=0, level=0; a new get 0x55 + send transmits 0x55 correctly.
REQ-043 CLKS_PER_BIT=1, STOP_BITS=2, LSB_FIRST=0; get 0x80, send -> tx 0,1,0,0,0,0,0,0,0,1,1 at one bit per cycle.
